// File: rtl/rf_wb_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter_pkg
// Shared constants for the register-file write-back arbiter:
//   DATA_W / REG_AW : register-file data and address widths
//   NREG            : number of architectural registers (busy vector width)
//   SRC_A / SRC_B   : request/grant bit index of execute / load unit
// ----------------------------------------------------------------------------
package rf_wb_arbiter_pkg;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 32;
    localparam int SRC_A  = 0;
    localparam int SRC_B  = 1;
endpackage

// File: rtl/rf_wb_arbiter_rr_arb2.sv
// ----------------------------------------------------------------------------
// rr_arb2
// Two-requester round-robin arbiter. When both request, the one that did not
// win the last grant is chosen. The pointer only moves on a grant.
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (pointer -> 0)
//   req_i  : request bits, index SRC_A / SRC_B
//   gnt_o  : one-hot (or zero) grant, combinational from req_i and pointer
// ----------------------------------------------------------------------------
module rr_arb2
    import rf_wb_arbiter_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic last_b_q, last_b_d;

    always_comb begin
        gnt_o        = '0;
        // B wins when alone, or when both request and A won last time.
        gnt_o[SRC_B] = req_i[SRC_B] & (~req_i[SRC_A] | ~last_b_q);
        gnt_o[SRC_A] = req_i[SRC_A] & ~gnt_o[SRC_B];

        last_b_d = last_b_q;
        if (|gnt_o) last_b_d = gnt_o[SRC_B];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) last_b_q <= 1'b0;
        else       last_b_q <= last_b_d;
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// ----------------------------------------------------------------------------
// rf_wb_arbiter
// Write-back arbiter and pending-write scoreboard for the single register
// file write port.
//   clk_i, rst_i              : clock, synchronous active-high reset
//   iss_valid_i/iss_rd_i      : decode issuing an instruction writing iss_rd_i
//   iss_ready_o               : issue accepted (destination not pending)
//   a_* / b_*                 : execute / load-unit result handshakes
//   we_o, wr_o, wd_o          : registered register-file write port
//   busy_o                    : per-register pending-write bits (bit 0 = 0)
// ----------------------------------------------------------------------------
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = rf_wb_arbiter_pkg::DATA_W,
    parameter int REG_AW = rf_wb_arbiter_pkg::REG_AW
) (
    input  logic              clk_i,
    input  logic              rst_i,

    input  logic              iss_valid_i,
    input  logic [REG_AW-1:0] iss_rd_i,
    output logic              iss_ready_o,

    input  logic              a_valid_i,
    input  logic [REG_AW-1:0] a_rd_i,
    input  logic [DATA_W-1:0] a_data_i,
    output logic              a_ready_o,

    input  logic              b_valid_i,
    input  logic [REG_AW-1:0] b_rd_i,
    input  logic [DATA_W-1:0] b_data_i,
    output logic              b_ready_o,

    output logic              we_o,
    output logic [REG_AW-1:0] wr_o,
    output logic [DATA_W-1:0] wd_o,
    output logic [NREG-1:0]   busy_o
);

    logic [NREG-1:0]   busy_q, busy_d;
    logic              we_q, we_d;
    logic [REG_AW-1:0] wr_q, wr_d;
    logic [DATA_W-1:0] wd_q, wd_d;

    logic [1:0]        req, gnt;
    logic              acc;
    logic [REG_AW-1:0] acc_rd;
    logic [DATA_W-1:0] acc_data;

    // No handshake completes while reset is held: anything accepted then
    // would be thrown away by the reset of the write port.
    assign req = {b_valid_i, a_valid_i} & {2{~rst_i}};

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (req),
        .gnt_o (gnt)
    );

    assign a_ready_o = gnt[SRC_A];
    assign b_ready_o = gnt[SRC_B];
    assign acc       = |gnt;
    assign acc_rd    = gnt[SRC_B] ? b_rd_i   : a_rd_i;
    assign acc_data  = gnt[SRC_B] ? b_data_i : a_data_i;

    // Ready looks at the current busy state, so a register whose write is
    // on the port this cycle (busy still 1) refuses a new issue until the
    // clear has landed; set and clear never target the same bit.
    assign iss_ready_o = ~rst_i & ~busy_q[iss_rd_i];

    always_comb begin
        busy_d = busy_q;
        if (we_q) busy_d[wr_q] = 1'b0;
        if (iss_valid_i && iss_ready_o && (iss_rd_i != '0))
            busy_d[iss_rd_i] = 1'b1;
        busy_d[0] = 1'b0;

        // rd = 0 results complete the handshake but never write.
        we_d = acc && (acc_rd != '0);
        wr_d = acc ? acc_rd   : wr_q;
        wd_d = acc ? acc_data : wd_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q <= '0;
            we_q   <= 1'b0;
            wr_q   <= '0;
            wd_q   <= '0;
        end else begin
            busy_q <= busy_d;
            we_q   <= we_d;
            wr_q   <= wr_d;
            wd_q   <= wd_d;
        end
    end

    assign busy_o = busy_q;
    assign we_o   = we_q;
    assign wr_o   = wr_q;
    assign wd_o   = wd_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
module tb_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        iss_valid_i;
    logic [4:0]  iss_rd_i;
    logic        iss_ready_o;
    logic        a_valid_i, b_valid_i;
    logic [4:0]  a_rd_i, b_rd_i;
    logic [31:0] a_data_i, b_data_i;
    logic        a_ready_o, b_ready_o;
    logic        we_o;
    logic [4:0]  wr_o;
    logic [31:0] wd_o;
    logic [31:0] busy_o;

    rf_wb_arbiter dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .iss_valid_i(iss_valid_i), .iss_rd_i(iss_rd_i), .iss_ready_o(iss_ready_o),
        .a_valid_i(a_valid_i), .a_rd_i(a_rd_i), .a_data_i(a_data_i), .a_ready_o(a_ready_o),
        .b_valid_i(b_valid_i), .b_rd_i(b_rd_i), .b_data_i(b_data_i), .b_ready_o(b_ready_o),
        .we_o(we_o), .wr_o(wr_o), .wd_o(wd_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        iss_v; logic [4:0] iss_rd;
        logic        a_v;   logic [4:0] a_rd; logic [31:0] a_d;
        logic        b_v;   logic [4:0] b_rd; logic [31:0] b_d;
        logic        e_iss, e_a, e_b;
        logic [31:0] e_busy;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    vec_t vecs[$];
    wr_t  sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input logic iv, input logic [4:0] ir,
                                input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                input logic bv, input logic [4:0] br, input logic [31:0] bd,
                                input logic ei, input logic ea, input logic eb,
                                input logic [31:0] ebusy);
        vec_t v;
        v.iss_v = iv; v.iss_rd = ir;
        v.a_v = av; v.a_rd = ar; v.a_d = ad;
        v.b_v = bv; v.b_rd = br; v.b_d = bd;
        v.e_iss = ei; v.e_a = ea; v.e_b = eb; v.e_busy = ebusy;
        return v;
    endfunction

    task automatic idle_inputs();
        iss_valid_i = 0; iss_rd_i = 0;
        a_valid_i = 0; a_rd_i = 0; a_data_i = 0;
        b_valid_i = 0; b_rd_i = 0; b_data_i = 0;
    endtask

    // Write-port monitor: a result accepted in cycle N must appear on the
    // port in cycle N+1 and nowhere else; otherwise we_o must be low.
    always @(negedge clk_i) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
                chk("we_o", {31'd0, we_o}, 32'd1);
                chk("wr_o", {27'd0, wr_o}, {27'd0, sb[0].rd});
                chk("wd_o", wd_o, sb[0].data);
                void'(sb.pop_front());
            end else begin
                chk("we_o_idle", {31'd0, we_o}, 32'd0);
                if (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
                    chk("sb_stale", 32'd1, 32'd0);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        wr_t e;
        rst_i = 1;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1 rst_i = 0;

        // Reset state
        #3;
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_we",   {31'd0, we_o}, 32'd0);
        chk("rst_wr",   {27'd0, wr_o}, 32'd0);
        chk("rst_wd",   wd_o, 32'd0);
        for (int r = 0; r < 32; r += 7) begin
            iss_rd_i = 5'(r);
            #0.1;
            chk("rst_iss_ready", {31'd0, iss_ready_o}, 32'd1);
        end
        iss_rd_i = 0;
        mon_en = 1;

        //           iv ir  av ar ad            bv br bd          ei ea eb busy
        vecs.push_back(mk(1, 5, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 5, 0, 0, 0,            0, 0, 0,          0, 0, 0, 32'h20));
        vecs.push_back(mk(0, 5, 1, 5, 32'hDEADBEEF, 0, 0, 0,          0, 1, 0, 32'h20));
        vecs.push_back(mk(0, 5, 0, 0, 0,            0, 0, 0,          0, 0, 0, 32'h20));
        vecs.push_back(mk(0, 5, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h0));
        // Both sources streaming: B, A, B, A, B, A
        vecs.push_back(mk(0, 0, 1, 1, 32'hA1,       1, 4, 32'hB4,     1, 0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 1, 32'hA1,       1, 5, 32'hB5,     1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 2, 32'hA2,       1, 5, 32'hB5,     1, 0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 2, 32'hA2,       1, 6, 32'hB6,     1, 1, 0, 32'h0));
        vecs.push_back(mk(0, 0, 1, 3, 32'hA3,       1, 6, 32'hB6,     1, 0, 1, 32'h0));
        vecs.push_back(mk(0, 0, 1, 3, 32'hA3,       0, 0, 0,          1, 1, 0, 32'h0));
        // rd = 0 result: handshake completes, no write
        vecs.push_back(mk(0, 0, 0, 0, 0,            1, 0, 32'h1234,   1, 0, 1, 32'h0));
        // Clear of r7 coincides with re-issue of r7
        vecs.push_back(mk(1, 7, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 7, 1, 7, 32'h77,       0, 0, 0,          0, 1, 0, 32'h80));
        vecs.push_back(mk(1, 7, 0, 0, 0,            0, 0, 0,          0, 0, 0, 32'h80));
        vecs.push_back(mk(1, 7, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 0, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h80));
        // Set r9 while r7 clears
        vecs.push_back(mk(1, 9, 1, 7, 32'h5,        0, 0, 0,          1, 1, 0, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h280));
        vecs.push_back(mk(0, 0, 0, 0, 0,            0, 0, 0,          1, 0, 0, 32'h200));

        foreach (vecs[i]) begin
            @(posedge clk_i);
            #1;
            iss_valid_i = vecs[i].iss_v; iss_rd_i = vecs[i].iss_rd;
            a_valid_i = vecs[i].a_v; a_rd_i = vecs[i].a_rd; a_data_i = vecs[i].a_d;
            b_valid_i = vecs[i].b_v; b_rd_i = vecs[i].b_rd; b_data_i = vecs[i].b_d;
            #3;
            chk($sformatf("v%0d_iss_ready", i), {31'd0, iss_ready_o}, {31'd0, vecs[i].e_iss});
            chk($sformatf("v%0d_a_ready", i),   {31'd0, a_ready_o},   {31'd0, vecs[i].e_a});
            chk($sformatf("v%0d_b_ready", i),   {31'd0, b_ready_o},   {31'd0, vecs[i].e_b});
            chk($sformatf("v%0d_busy", i),      busy_o,               vecs[i].e_busy);
            if (vecs[i].e_a && vecs[i].a_rd != 0) begin
                e.rd = vecs[i].a_rd; e.data = vecs[i].a_d; e.cyc = cyc; sb.push_back(e);
            end
            if (vecs[i].e_b && vecs[i].b_rd != 0) begin
                e.rd = vecs[i].b_rd; e.data = vecs[i].b_d; e.cyc = cyc; sb.push_back(e);
            end
        end

        // Reset while a result is offered and r9 is pending
        @(posedge clk_i);
        #1;
        idle_inputs();
        rst_i = 1; a_valid_i = 1; a_rd_i = 9; a_data_i = 32'hBAD0BAD0;
        @(posedge clk_i);
        #1;
        rst_i = 0; idle_inputs(); iss_rd_i = 9;
        #3;
        chk("post_rst_we",    {31'd0, we_o}, 32'd0);
        chk("post_rst_busy",  busy_o, 32'd0);
        chk("post_rst_ready", {31'd0, iss_ready_o}, 32'd1);
        @(posedge clk_i);
        #4;
        chk("post_rst_we2",   {31'd0, we_o}, 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected end before 100000");
        $fatal(1);
    end

endmodule
